// File: rtl/correlator_bank.sv
// correlator_bank: N-tap early/prompt/late PRN correlator with ±1 I/Q integration and a
// single time-shared I^2+Q^2 squarer. Define CORR_DISC_EN to add the early-minus-late `disc` output.
module correlator_bank #(
   parameter int unsigned N_TAPS  = 3,
   parameter int unsigned TAP_DLY = 1,
   parameter int unsigned ACC_LEN = 1000,
   parameter int unsigned ACC_W   = $clog2(ACC_LEN) + 2,
   parameter int unsigned PWR_W   = 2 * ACC_W
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    sample_en,
   input  logic                    data_in,
   input  logic                    prn_in,
   input  logic                    sin_in,
   input  logic                    cos_in,
   input  logic                    acc_clr,
   output logic [N_TAPS*PWR_W-1:0] power,
   output logic                    pwr_valid,
   output logic                    sq_busy
`ifdef CORR_DISC_EN
   ,
   output logic signed [PWR_W:0]   disc
`endif
);

   localparam int unsigned DL_LEN = (N_TAPS - 1) * TAP_DLY;
   localparam int unsigned DL_W   = (DL_LEN == 0) ? 1 : DL_LEN;
   localparam int unsigned CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int unsigned TAP_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int unsigned IDX_W  = TAP_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_SQ, S_DONE} sq_state_e;

   if ((ACC_LEN < 2 * N_TAPS + 2) || (N_TAPS % 2 == 0)) begin : g_bad_param
      $error("correlator_bank: N_TAPS must be odd and ACC_LEN >= 2*N_TAPS+2");
   end

   logic [DL_W-1:0]         dl_q;
   logic [N_TAPS-1:0]       tap_c;
   logic [CNT_W-1:0]        cnt_q;
   logic                    dump_c;
   logic                    start_q;
   logic signed [ACC_W-1:0] snap_i_c [N_TAPS];
   logic signed [ACC_W-1:0] snap_q_c [N_TAPS];

   sq_state_e               state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [PWR_W-1:0]        part_q, part_d;
   logic [PWR_W-1:0]        pwr_q [N_TAPS];
   logic [PWR_W-1:0]        pwr_d [N_TAPS];
   logic                    pwr_valid_q, pwr_valid_d;
   logic                    sq_busy_q, sq_busy_d;
   logic [TAP_W-1:0]        sel_c;
   logic signed [ACC_W-1:0] op_c;
   logic [ACC_W-1:0]        mag_c;
   logic [PWR_W-1:0]        sq_c;

   // Final sample of the integration; a simultaneous clear cancels the dump.
   assign dump_c = sample_en && !acc_clr && (cnt_q == CNT_W'(ACC_LEN - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         dl_q    <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         start_q <= dump_c;
         if (sample_en) dl_q <= DL_W'({dl_q, prn_in});
         if (acc_clr) cnt_q <= '0;
         else if (sample_en) cnt_q <= dump_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      logic signed [ACC_W-1:0] acc_i_q, acc_q_q, snap_i_q, snap_q_q, sum_i_c, sum_q_c;

      if (k == 0) begin : g_t0
         assign tap_c[k] = prn_in;
      end else begin : g_tk
         assign tap_c[k] = dl_q[k*TAP_DLY-1];
      end

      assign sum_i_c = (data_in ^ tap_c[k] ^ sin_in) ? acc_i_q - ACC_W'(1) : acc_i_q + ACC_W'(1);
      assign sum_q_c = (data_in ^ tap_c[k] ^ cos_in) ? acc_q_q - ACC_W'(1) : acc_q_q + ACC_W'(1);

      // The dumping sample lands in the snapshot while the accumulator restarts from zero.
      always_ff @(posedge CLK) begin
         if (!RST) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            snap_i_q <= '0;
            snap_q_q <= '0;
         end else begin
            if (acc_clr || dump_c) begin
               acc_i_q <= '0;
               acc_q_q <= '0;
            end else if (sample_en) begin
               acc_i_q <= sum_i_c;
               acc_q_q <= sum_q_c;
            end
            if (dump_c) begin
               snap_i_q <= sum_i_c;
               snap_q_q <= sum_q_c;
            end
         end
      end

      assign snap_i_c[k] = snap_i_q;
      assign snap_q_c[k] = snap_q_q;
      assign power[k*PWR_W +: PWR_W] = pwr_q[k];
   end

   // Shared squarer: even step squares I of a tap, odd step adds Q^2 and commits.
   assign sel_c = idx_q[IDX_W-1:1];
   assign op_c  = idx_q[0] ? snap_q_c[sel_c] : snap_i_c[sel_c];
   assign mag_c = op_c[ACC_W-1] ? ACC_W'(-op_c) : ACC_W'(op_c);
   assign sq_c  = PWR_W'(mag_c) * PWR_W'(mag_c);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         part_q      <= '0;
         pwr_q       <= '{default: '0};
         pwr_valid_q <= 1'b0;
         sq_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         part_q      <= part_d;
         pwr_q       <= pwr_d;
         pwr_valid_q <= pwr_valid_d;
         sq_busy_q   <= sq_busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      part_d      = part_q;
      pwr_d       = pwr_q;
      pwr_valid_d = 1'b0;
      sq_busy_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_q) begin
               state_d = S_SQ;
               idx_d   = '0;
            end
         end
         S_SQ: begin
            if (idx_q[0]) pwr_d[sel_c] = part_q + sq_c;
            else          part_d       = sq_c;
            if (idx_q == IDX_W'(2 * N_TAPS - 1)) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE:  state_d = start_q ? S_SQ : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      pwr_valid_d = (state_d == S_DONE);
      sq_busy_d   = (state_d != S_IDLE);
   end

   assign pwr_valid = pwr_valid_q;
   assign sq_busy   = sq_busy_q;

`ifdef CORR_DISC_EN
   logic signed [PWR_W:0] disc_q;

   // Uses next-state powers so the latest tap written in the final SQ step is included.
   always_ff @(posedge CLK) begin
      if (!RST) disc_q <= '0;
      else if (pwr_valid_d) disc_q <= $signed({1'b0, pwr_d[0]}) - $signed({1'b0, pwr_d[N_TAPS-1]});
   end

   assign disc = disc_q;
`endif

endmodule

// File: tb/tb_correlator_bank.sv
// Bench for correlator_bank: sample-list reference model scored every cycle, plus fixed-pattern power literals.
module tb_correlator_bank;

   localparam int unsigned N_TAPS  = 3;
   localparam int unsigned TAP_DLY = 1;
   localparam int unsigned ACC_LEN = 16;
   localparam int unsigned ACC_W   = $clog2(ACC_LEN) + 2;
   localparam int unsigned PWR_W   = 2 * ACC_W;
   localparam int unsigned BUS_W   = N_TAPS * PWR_W;
   localparam int          LAT     = 2 * N_TAPS + 1;
   localparam int          DL_LEN  = (N_TAPS - 1) * TAP_DLY;
   localparam logic [BUS_W-1:0] LIT_P = {12'd128, 12'd512, 12'd128};
   localparam logic [BUS_W-1:0] LIT_E = {12'd0, 12'd128, 12'd512};

   logic CLK = 1'b0, RST = 1'b0, sample_en = 1'b0, data_in = 1'b0, prn_in = 1'b0;
   logic sin_in = 1'b0, cos_in = 1'b0, acc_clr = 1'b0;
   logic [BUS_W-1:0] power;
   logic pwr_valid, sq_busy;
`ifdef CORR_DISC_EN
   logic signed [PWR_W:0] disc;
`endif

   correlator_bank #(.N_TAPS(N_TAPS), .TAP_DLY(TAP_DLY), .ACC_LEN(ACC_LEN)) dut (
      .CLK(CLK), .RST(RST), .sample_en(sample_en), .data_in(data_in), .prn_in(prn_in),
      .sin_in(sin_in), .cos_in(cos_in), .acc_clr(acc_clr), .power(power),
      .pwr_valid(pwr_valid), .sq_busy(sq_busy)
`ifdef CORR_DISC_EN
      , .disc(disc)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed { logic d; logic s; logic c; logic [N_TAPS-1:0] tap; } samp_t;
   typedef struct packed { int due; logic [BUS_W-1:0] pw; } dump_t;

   samp_t win[$];
   logic  hist[$];
   dump_t pend[$];
   int    edge_n = 0, checks = 0, failures = 0, ph = 0;
   logic  prev = 1'b0;
   logic  m_valid = 1'b0, m_busy = 1'b0;
   logic [BUS_W-1:0] m_power = '0;
   int    m_disc = 0;

   // Reference model: collect the window's samples, then compute sums and powers arithmetically.
   task automatic model_edge(input logic rst, en, d, p, s, c, clr);
      samp_t sm;
      int vi, vq;
      logic [BUS_W-1:0] pw;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      if (!rst) begin
         win.delete(); pend.delete(); hist.delete();
         for (int i = 0; i < DL_LEN; i++) hist.push_back(1'b0);
         m_power = '0;
         m_disc  = 0;
      end else begin
         if (en) begin
            sm.d = d; sm.s = s; sm.c = c; sm.tap[0] = p;
            for (int k = 1; k < N_TAPS; k++) sm.tap[k] = hist[k*TAP_DLY-1];
            hist.push_front(p);
            void'(hist.pop_back());
            if (!clr) win.push_back(sm);
         end
         if (clr) win.delete();
         else if (win.size() == ACC_LEN) begin
            pw = '0;
            for (int k = 0; k < N_TAPS; k++) begin
               vi = 0; vq = 0;
               foreach (win[n]) begin
                  vi += (win[n].d ^ win[n].tap[k] ^ win[n].s) ? -1 : 1;
                  vq += (win[n].d ^ win[n].tap[k] ^ win[n].c) ? -1 : 1;
               end
               pw[k*PWR_W +: PWR_W] = PWR_W'(vi * vi + vq * vq);
            end
            pend.push_back('{due: edge_n + LAT, pw: pw});
            win.delete();
         end
         if (pend.size() > 0) begin
            m_busy = (edge_n >= pend[0].due - (LAT - 1)) && (edge_n <= pend[0].due);
            if (pend[0].due == edge_n) begin
               m_valid = 1'b1;
               m_power = pend[0].pw;
               m_disc  = int'(pend[0].pw[PWR_W-1:0]) - int'(pend[0].pw[(N_TAPS-1)*PWR_W +: PWR_W]);
               void'(pend.pop_front());
            end
         end
      end
   endtask

   task automatic cyc(input logic rst, en, d, p, s, c, clr);
      RST = rst; sample_en = en; data_in = d; prn_in = p; sin_in = s; cos_in = c; acc_clr = clr;
      @(posedge CLK);
      edge_n++;
      model_edge(rst, en, d, p, s, c, clr);
      #1;
   endtask

   // prn = 11100000 repeating; mode 0 prompt-aligned data, 1 inverted prompt, 2 early-aligned.
   task automatic pat_next(input int mode, output logic d, output logic p);
      logic [7:0] pat;
      pat = 8'b11100000;
      p = pat[3'(7 - ph)];
      ph = (ph + 1) % 8;
      if (mode == 0)      d = prev;
      else if (mode == 1) d = ~prev;
      else                d = p;
      prev = p;
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ph = 0;
      prev = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (power !== '0) begin failures++; $display("FAIL reset_power got=%h exp=0", power); end
         checks++;
         if (pwr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pwr_valid); end
         checks++;
         if (sq_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", sq_busy); end
`ifdef CORR_DISC_EN
         checks++;
         if (disc !== '0) begin failures++; $display("FAIL reset_disc got=%0d exp=0", disc); end
`endif
      end
   endtask

   task automatic test_alignment(input string name, input int mode, input bit half, input logic [BUS_W-1:0] lit);
      int nv, ncyc;
      logic d, p, en;
      nv = 0;
      ncyc = 3 * ACC_LEN * (half ? 2 : 1);
      do_reset();
      for (int n = 0; n < ncyc + LAT + 2; n++) begin
         en = (n < ncyc) && (!half || (n % 2 == 0));
         if (en) pat_next(mode, d, p);
         else begin d = 1'($urandom); p = 1'($urandom); end
         cyc(1'b1, en, d, p, en ? 1'b0 : 1'($urandom), en ? 1'b1 : 1'($urandom), 1'b0);
         checks++;
         if (pwr_valid !== m_valid) begin failures++; $display("FAIL %s_valid edge=%0d got=%b exp=%b", name, edge_n, pwr_valid, m_valid); end
         checks++;
         if (sq_busy !== m_busy) begin failures++; $display("FAIL %s_busy edge=%0d got=%b exp=%b", name, edge_n, sq_busy, m_busy); end
         if (m_valid) begin
            nv++;
            checks++;
            if (power !== m_power) begin failures++; $display("FAIL %s_power edge=%0d got=%h exp=%h", name, edge_n, power, m_power); end
            checks++;
            if (power !== lit) begin failures++; $display("FAIL %s_literal edge=%0d got=%h exp=%h", name, edge_n, power, lit); end
`ifdef CORR_DISC_EN
            checks++;
            if (disc !== (PWR_W+1)'(m_disc)) begin failures++; $display("FAIL %s_disc got=%0d exp=%0d", name, disc, m_disc); end
            if (mode == 2) begin
               checks++;
               if (disc !== (PWR_W+1)'(512)) begin failures++; $display("FAIL %s_disc512 got=%0d exp=512", name, disc); end
            end
`endif
         end
      end
      checks++;
      if (nv != 3) begin failures++; $display("FAIL %s_dump_count got=%0d exp=3", name, nv); end
   endtask

   task automatic test_acc_clr();
      int nv, clr_edge, first_edge;
      logic d, p, clr;
      nv = 0; clr_edge = 0; first_edge = -1;
      do_reset();
      for (int n = 1; n <= 10 + 2 * ACC_LEN + LAT + 2; n++) begin
         clr = (n == 10);
         if (n <= 10 + 2 * ACC_LEN) pat_next(0, d, p);
         else begin d = 1'($urandom); p = 1'($urandom); end
         cyc(1'b1, n <= 10 + 2 * ACC_LEN, d, p, 1'b0, 1'b1, clr);
         if (clr) clr_edge = edge_n;
         checks++;
         if (pwr_valid !== m_valid) begin failures++; $display("FAIL clr_valid edge=%0d got=%b exp=%b", edge_n, pwr_valid, m_valid); end
         checks++;
         if (sq_busy !== m_busy) begin failures++; $display("FAIL clr_busy edge=%0d got=%b exp=%b", edge_n, sq_busy, m_busy); end
         if (pwr_valid === 1'b1) begin
            nv++;
            if (first_edge < 0) first_edge = edge_n;
            checks++;
            if (power !== LIT_P) begin failures++; $display("FAIL clr_power edge=%0d got=%h exp=%h", edge_n, power, LIT_P); end
         end
      end
      checks++;
      if (first_edge != clr_edge + ACC_LEN + LAT) begin
         failures++; $display("FAIL clr_first_valid got_edge=%0d exp_edge=%0d", first_edge, clr_edge + ACC_LEN + LAT);
      end
      checks++;
      if (nv != 2) begin failures++; $display("FAIL clr_dump_count got=%0d exp=2", nv); end
   endtask

   task automatic test_rst_mid_sq();
      logic d, p;
      do_reset();
      for (int n = 0; n < ACC_LEN; n++) begin
         pat_next(0, d, p);
         cyc(1'b1, 1'b1, d, p, 1'b0, 1'b1, 1'b0);
      end
      for (int n = 0; n < 3; n++) begin
         cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
         checks++;
         if (sq_busy !== 1'b1) begin failures++; $display("FAIL rstsq_busy_pre cyc=%0d got=%b exp=1", n, sq_busy); end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (power !== '0) begin failures++; $display("FAIL rstsq_power got=%h exp=0", power); end
      checks++;
      if (sq_busy !== 1'b0) begin failures++; $display("FAIL rstsq_busy got=%b exp=0", sq_busy); end
      for (int n = 0; n < 12; n++) begin
         cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
         checks++;
         if (pwr_valid !== 1'b0) begin failures++; $display("FAIL rstsq_valid cyc=%0d got=%b exp=0", n, pwr_valid); end
         checks++;
         if (sq_busy !== 1'b0) begin failures++; $display("FAIL rstsq_busy_post cyc=%0d got=%b exp=0", n, sq_busy); end
      end
   endtask

   task automatic test_random();
      logic en, clr;
      do_reset();
      for (int n = 0; n < 400 + LAT + 2; n++) begin
         en  = (n < 400) && ($urandom_range(0, 3) != 0);
         clr = (n < 400) && ($urandom_range(0, 63) == 0);
         cyc(1'b1, en, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), clr);
         checks++;
         if (pwr_valid !== m_valid) begin failures++; $display("FAIL rand_valid edge=%0d got=%b exp=%b", edge_n, pwr_valid, m_valid); end
         checks++;
         if (sq_busy !== m_busy) begin failures++; $display("FAIL rand_busy edge=%0d got=%b exp=%b", edge_n, sq_busy, m_busy); end
         if (m_valid) begin
            checks++;
            if (power !== m_power) begin failures++; $display("FAIL rand_power edge=%0d got=%h exp=%h", edge_n, power, m_power); end
`ifdef CORR_DISC_EN
            checks++;
            if (disc !== (PWR_W+1)'(m_disc)) begin failures++; $display("FAIL rand_disc got=%0d exp=%0d", disc, m_disc); end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_alignment("prompt", 0, 1'b0, LIT_P);
      test_alignment("inverted", 1, 1'b0, LIT_P);
      test_alignment("half_rate", 0, 1'b1, LIT_P);
      test_acc_clr();
      test_rst_mid_sq();
      test_random();
`ifdef CORR_DISC_EN
      test_alignment("disc", 2, 1'b0, LIT_E);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/correlator_bank.md
# correlator_bank

Parametrised multi-tap GPS code correlator: N_TAPS early/prompt/late replicas taken from one PRN delay line, each mixed with the local sin/cos carrier, integrated as signed ±1 I/Q sums over ACC_LEN samples, then reduced to I²+Q² power by a single time-shared squarer. It replaces the fixed early/late XOR → summation_sqr pairs and the external 10 kHz dump prescaler in the tracking top. It feeds the code-loop discriminator and the Costas loop.

## Interface
- N_TAPS, 3: number of replica taps; tap 0 = earliest, tap N_TAPS-1 = latest; odd values only, centre tap = prompt.
- TAP_DLY, 1: sample spacing between adjacent taps.
- ACC_LEN, 1000: enabled samples per integration; must be ≥ 2*N_TAPS+2 (elaboration check).
- ACC_W, $clog2(ACC_LEN)+2: signed accumulator width (derived).
- PWR_W, 2*ACC_W: unsigned per-tap power width (derived).
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-low.
- sample_en  in  1  qualifies data_in/prn_in/sin_in/cos_in for this cycle.
- data_in  in  1  hard-limited IF sample.
- prn_in  in  1  PRN replica, earliest phase.
- sin_in, cos_in  in  1 each  local carrier bits.
- acc_clr  in  1  abort current integration, restart count.
- power  out  N_TAPS*PWR_W  tap k at bits [k*PWR_W +: PWR_W].
- pwr_valid  out  1  one-cycle strobe, power updated.
- sq_busy  out  1  squarer running.
- disc  out  PWR_W+1 signed  early-minus-late power (DISC_EN only).

## Operation
- Delay line: (N_TAPS-1)*TAP_DLY bits, shifts on sample_en only; tap k = prn_in delayed k*TAP_DLY enabled samples (tap 0 = prn_in).
- Per tap, on sample_en: I_k += (data_in^tap_k^sin_in) ? −1 : +1; Q_k likewise with cos_in.
- Sample counter 0..ACC_LEN-1 advances on sample_en. On the enabled sample at count ACC_LEN-1: that sample is included, all I/Q copied to snapshot registers, accumulators and counter cleared for the next sample (no sample lost), squarer started.
- Squarer FSM: IDLE → SQ (2*N_TAPS cycles; cycle 2t squares I_t, cycle 2t+1 squares Q_t, adds, writes power tap t) → DONE (1 cycle, pwr_valid=1) → IDLE. sq_busy=1 in SQ and DONE.
- Power regs per tap written during SQ; whole bus is only guaranteed coherent at pwr_valid; held until the next update.
- Squares exact: |I|,|Q| ≤ ACC_LEN, so no saturation is needed at these widths.
- acc_clr: clears accumulators, counter, delay line untouched; has priority over a simultaneous dump (no snapshot, no start). A running SQ completes from its snapshot.
- Reset: accumulators, counter, snapshot, delay line, power, disc = 0; pwr_valid = 0, sq_busy = 0, FSM = IDLE. Reset mid-SQ aborts with no pwr_valid.

## Timing
- Edge E captures the final sample; snapshot valid after E; SQ cycles E+1..E+2*N_TAPS; pwr_valid high in cycle E+2*N_TAPS+1 (7 cycles for N_TAPS=3).
- Parameter bound guarantees a new dump cannot arrive before DONE.
- No input handshake; sample_en may toggle every cycle or be held high.

## Configuration
- CORR_DISC_EN defined: disc = power[0] − power[N_TAPS-1], registered, updated in the same cycle as pwr_valid; reset 0.
- Undefined: disc port absent, no subtractor.

## Test plan
(N_TAPS=3, TAP_DLY=1, ACC_LEN=16, prn_in = 11100000 repeating, sin_in=0, cos_in=1, sample_en=1.)
- data_in = prn_in delayed 1 (prompt-aligned) → power = {128, 512, 128} (early, prompt, late); pwr_valid exactly 7 cycles after the 16th sample edge, repeats every 16 samples.
- data_in inverted from the previous test → identical powers (sign independence).
- sample_en high every other cycle, same data → identical powers; dump after 16 enabled samples (32 cycles).
- acc_clr asserted on sample 10 → no pwr_valid at sample 16; first pwr_valid 7 cycles after the 16th post-clear sample with the expected powers.
- RST low during the 3rd SQ cycle → pwr_valid never asserts; power = 0 and sq_busy = 0 after the reset edge.
- CORR_DISC_EN, data_in = prn_in (early-aligned) → power = {512, 128, 0}; disc = +512 in the pwr_valid cycle.
